// File: rtl/ladybird_config.sv
// Shared types and RV32I instruction constructors for the ladybird instruction generator.
package ladybird_config;

    typedef enum logic [1:0] {
        OP_LI   = 2'd0,
        OP_SB   = 2'd1,
        OP_JUMP = 2'd2,
        OP_RAW  = 2'd3
    } inst_gen_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } inst_gen_state_t;

    // Command as held in the FIFO: {op, rd, rs, data}
    typedef struct packed {
        inst_gen_op_t op;
        logic [4:0]   rd;
        logic [4:0]   rs;
        logic [31:0]  data;
    } inst_gen_cmd_t;

    localparam int CMD_W = $bits(inst_gen_cmd_t);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_JALR   = 3'b000;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [4:0] REG_X0    = 5'd0;

    // Upper 20 bits corrected for the sign extension of the low 12 bits
    function automatic logic [19:0] HI_ADJ(input logic [31:0] imm);
        return imm[31:12] + {19'd0, imm[11]};
    endfunction

    function automatic logic [11:0] LO(input logic [31:0] imm);
        return imm[11:0];
    endfunction

    // True when the value is reproduced by sign-extending its low 12 bits
    function automatic logic FITS_IMM12(input logic [31:0] imm);
        return (imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF);
    endfunction

    function automatic logic [31:0] LUI(input logic [4:0] rd, input logic [19:0] hi);
        return {hi, rd, OPC_LUI};
    endfunction

    function automatic logic [31:0] ADDI(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, F3_ADDI, rd, OPC_OPIMM};
    endfunction

    function automatic logic [31:0] JALR(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, F3_JALR, rd, OPC_JALR};
    endfunction

    function automatic logic [31:0] SB_S(input logic [4:0] rs2, input logic [11:0] offset,
                                         input logic [4:0] base);
        return {offset[11:5], rs2, base, F3_SB, offset[4:0], OPC_STORE};
    endfunction

endpackage

// File: rtl/ladybird_sync_fifo.sv
// Synchronous FIFO with extra-bit wrapping pointers and first-word-fall-through read.
module ladybird_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // Head is read combinationally so a pop can load the output register in the same cycle
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer update
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ladybird_inst_gen.sv
// RV32I instruction sequencer: expands buffered high-level commands into instruction words.
// Optional feature macro: LADYBIRD_INST_GEN_COUNT_EN adds the inst_count handshake counter.
module ladybird_inst_gen
    import ladybird_config::*;
#(
    parameter int         DEPTH       = 4,
    parameter logic [4:0] SCRATCH_REG = 5'd31
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs,
    input  logic [31:0] cmd_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data
`ifdef LADYBIRD_INST_GEN_COUNT_EN
    ,
    output logic [31:0] inst_count
`endif
);
    inst_gen_state_t state_reg, state_next;
    inst_gen_cmd_t   push_cmd, head_cmd;
    logic            fifo_full, fifo_empty, fifo_pop, push;
    logic            load_first, load_second, clear_valid, handshake;
    logic [31:0]     head_first, head_second;
    logic            head_two;
    logic [31:0]     inst_data_reg, second_reg;
    logic            inst_valid_reg, two_reg;

    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign handshake  = inst_valid_reg && inst_ready;
    assign inst_valid = inst_valid_reg;
    assign inst_data  = inst_data_reg;

    assign push_cmd.op   = inst_gen_op_t'(cmd_op);
    assign push_cmd.rd   = cmd_rd;
    assign push_cmd.rs   = cmd_rs;
    assign push_cmd.data = cmd_data;

    ladybird_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Expand the FIFO head into its one or two instruction words
    always_comb begin
        head_first  = head_cmd.data;
        head_second = 32'h0000_0000;
        head_two    = 1'b0;
        case (head_cmd.op)
            OP_LI: begin
                if (FITS_IMM12(head_cmd.data)) begin
                    head_first = ADDI(head_cmd.rd, REG_X0, LO(head_cmd.data));
                end else if (LO(head_cmd.data) == 12'h000) begin
                    head_first = LUI(head_cmd.rd, HI_ADJ(head_cmd.data));
                end else begin
                    head_first  = LUI(head_cmd.rd, HI_ADJ(head_cmd.data));
                    head_second = ADDI(head_cmd.rd, head_cmd.rd, LO(head_cmd.data));
                    head_two    = 1'b1;
                end
            end
            OP_SB: begin
                head_first  = LUI(SCRATCH_REG, HI_ADJ(head_cmd.data));
                head_second = SB_S(head_cmd.rs, LO(head_cmd.data), SCRATCH_REG);
                head_two    = 1'b1;
            end
            OP_JUMP: begin
                head_first  = LUI(SCRATCH_REG, HI_ADJ(head_cmd.data));
                head_second = JALR(head_cmd.rd, SCRATCH_REG, LO(head_cmd.data));
                head_two    = 1'b1;
            end
            default: begin
                head_first = head_cmd.data;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and datapath control; the final handshake chains straight into the next command
    always_comb begin
        state_next  = state_reg;
        fifo_pop    = 1'b0;
        load_first  = 1'b0;
        load_second = 1'b0;
        clear_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load_first = 1'b1;
                    state_next = ST_FIRST;
                end
            end
            ST_FIRST, ST_SECOND: begin
                if (handshake) begin
                    if (state_reg == ST_FIRST && two_reg) begin
                        load_second = 1'b1;
                        state_next  = ST_SECOND;
                    end else if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load_first = 1'b1;
                        state_next = ST_FIRST;
                    end else begin
                        clear_valid = 1'b1;
                        state_next  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered instruction output plus the pending second word of the held command
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            inst_valid_reg <= 1'b0;
            inst_data_reg  <= 32'h0000_0000;
            second_reg     <= 32'h0000_0000;
            two_reg        <= 1'b0;
        end else if (load_first) begin
            inst_valid_reg <= 1'b1;
            inst_data_reg  <= head_first;
            second_reg     <= head_second;
            two_reg        <= head_two;
        end else if (load_second) begin
            inst_data_reg  <= second_reg;
        end else if (clear_valid) begin
            inst_valid_reg <= 1'b0;
        end
    end

`ifdef LADYBIRD_INST_GEN_COUNT_EN
    logic [31:0] count_reg;
    assign inst_count = count_reg;

    // Count instruction handshakes, wrapping naturally
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_reg <= 32'h0000_0000;
        end else if (handshake) begin
            count_reg <= count_reg + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ladybird_inst_gen.sv
// Directed self-checking bench for ladybird_inst_gen (DEPTH=4, SCRATCH_REG=x31).
module tb_ladybird_inst_gen;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_rd = 5'd0;
    logic [4:0]  cmd_rs = 5'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
`ifdef LADYBIRD_INST_GEN_COUNT_EN
    logic [31:0] inst_count;
`endif

    int tests = 0;
    int fails = 0;

    ladybird_inst_gen #(
        .DEPTH       (4),
        .SCRATCH_REG (5'd31)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs     (cmd_rs),
        .cmd_data   (cmd_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data)
`ifdef LADYBIRD_INST_GEN_COUNT_EN
        ,
        .inst_count (inst_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one command starting at a falling edge; returns on the falling edge after acceptance
    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_data  = d;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_ready", {31'd0, cmd_ready}, 32'd1);
        $display("[TB] cmd op=%0d rd=%0d rs=%0d data=%h", op, rd, rs, d);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for an instruction, check it, and accept it with a one-cycle ready pulse
    task automatic expect_inst(input string tag, input logic [31:0] exp);
        int n = 0;
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check(tag, inst_data, exp);
        $display("[TB] inst %s data=%h", tag, inst_data);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    logic [31:0] drain_exp [7];

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'h0000_0000);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef LADYBIRD_INST_GEN_COUNT_EN
        check("rst_count", inst_count, 32'd0);
`endif
        nrst = 1'b1;
        @(negedge clk);

        // LI small immediate: single ADDI, valid two cycles after acceptance
        send(2'd0, 5'd5, 5'd0, 32'h0000_0123);
        check("lat_n1", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        check("lat_n2", {31'd0, inst_valid}, 32'd1);
        expect_inst("li_small", 32'h1230_0293);
        check("li_small_end", {31'd0, inst_valid}, 32'd0);

        // LI with carry correction
        send(2'd0, 5'd5, 5'd0, 32'h1234_5FFF);
        expect_inst("li_carry_lui", 32'h1234_62B7);
        expect_inst("li_carry_addi", 32'hFFF2_8293);
        check("li_carry_end", {31'd0, inst_valid}, 32'd0);

        // LI with zero low part: LUI only
        send(2'd0, 5'd5, 5'd0, 32'h0000_1000);
        expect_inst("li_lui_only", 32'h0000_12B7);
        check("li_lui_only_end", {31'd0, inst_valid}, 32'd0);

        // JUMP through scratch register
        send(2'd2, 5'd1, 5'd0, 32'h8000_0800);
        expect_inst("jump_lui", 32'h8000_1FB7);
        expect_inst("jump_jalr", 32'h800F_80E7);

        // SB x7 to 0x1000_0004
        send(2'd1, 5'd0, 5'd7, 32'h1000_0004);
        expect_inst("sb_lui", 32'h1000_0FB7);
        expect_inst("sb_store", 32'h007F_8223);
        check("sb_end", {31'd0, inst_valid}, 32'd0);

        // Backpressure: five commands fit, the sixth is refused
        inst_ready = 1'b0;
        send(2'd3, 5'd0, 5'd0, 32'hA1A1_A1A1);
        send(2'd0, 5'd5, 5'd0, 32'h0000_0123);
        send(2'd0, 5'd5, 5'd0, 32'h1234_5FFF);
        send(2'd3, 5'd0, 5'd0, 32'hA2A2_A2A2);
        send(2'd2, 5'd1, 5'd0, 32'h8000_0800);
        check("full_ready", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("hold_data", inst_data, 32'hA1A1_A1A1);
            @(negedge clk);
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_data  = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            check("sixth_refused", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;

        drain_exp[0] = 32'hA1A1_A1A1;
        drain_exp[1] = 32'h1230_0293;
        drain_exp[2] = 32'h1234_62B7;
        drain_exp[3] = 32'hFFF2_8293;
        drain_exp[4] = 32'hA2A2_A2A2;
        drain_exp[5] = 32'h8000_1FB7;
        drain_exp[6] = 32'h800F_80E7;
        inst_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("drain_valid", {31'd0, inst_valid}, 32'd1);
            check("drain_data", inst_data, drain_exp[i]);
            $display("[TB] inst drain[%0d] data=%h", i, inst_data);
            @(negedge clk);
        end
        check("drain_end", {31'd0, inst_valid}, 32'd0);
        inst_ready = 1'b0;
`ifdef LADYBIRD_INST_GEN_COUNT_EN
        check("count_total", inst_count, 32'd15);
`endif

        // Reset in SECOND with three commands queued
        send(2'd2, 5'd1, 5'd0, 32'h8000_0800);
        send(2'd3, 5'd0, 5'd0, 32'h1111_1111);
        send(2'd3, 5'd0, 5'd0, 32'h2222_2222);
        send(2'd3, 5'd0, 5'd0, 32'h3333_3333);
        expect_inst("rst_jump_lui", 32'h8000_1FB7);
        check("second_data", inst_data, 32'h800F_80E7);
        nrst = 1'b0;
        #1;
        check("midrst_valid", {31'd0, inst_valid}, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef LADYBIRD_INST_GEN_COUNT_EN
        check("midrst_count", inst_count, 32'd0);
`endif
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        send(2'd3, 5'd0, 5'd0, 32'h0000_0013);
        expect_inst("post_rst_raw", 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_quiet", {31'd0, inst_valid}, 32'd0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
